// File: rtl/reg_write_encoder.sv
// Encodes one-hot register write requests into a regId stream with a valid/ready handshake
// and a one-hot grant back to the accepted source. Define WB_RR_ARB_EN for round-robin selection.
module reg_write_encoder #(
  parameter int NREG = 16,
  parameter int IDW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREG-1:0] req,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDW-1:0]  out_regid,
  output logic [NREG-1:0] grant
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_e;

  state_e          state_q;
  logic            out_valid_q;
  logic [IDW-1:0]  out_regid_q;
  logic            accept_s;
  logic [NREG-1:0] onehot_s;
  logic [NREG-1:0] cand_s;
  logic [IDW-1:0]  idle_start_s;
  logic [IDW-1:0]  hold_start_s;
  logic [IDW-1:0]  idle_sel_d;
  logic [IDW-1:0]  hold_sel_d;

  // First set bit of vec at or above start, wrapping modulo NREG.
  function automatic logic [IDW-1:0] pick(input logic [NREG-1:0] vec, input logic [IDW-1:0] start);
    logic [IDW-1:0] idx;
    logic           found;
    pick  = {IDW{1'b0}};
    found = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      idx = start + IDW'(k);
      if (!found && vec[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

`ifdef WB_RR_ARB_EN
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] rr_ptr_d;

  assign rr_ptr_d     = out_regid_q + IDW'(1);
  assign idle_start_s = rr_ptr_q;
  assign hold_start_s = rr_ptr_d;

  // Round-robin pointer: one past the most recently accepted regId.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= {IDW{1'b0}};
    end else if (accept_s) begin
      rr_ptr_q <= rr_ptr_d;
    end else begin
      rr_ptr_q <= rr_ptr_q;
    end
  end
`else
  assign idle_start_s = {IDW{1'b0}};
  assign hold_start_s = {IDW{1'b0}};
`endif

  // Handshake, grant decode and candidate selection.
  always_comb begin
    accept_s   = out_valid_q & out_ready;
    onehot_s   = {{(NREG-1){1'b0}}, 1'b1} << out_regid_q;
    grant      = accept_s ? onehot_s : {NREG{1'b0}};
    // The granted source still shows req this cycle, so it must not win again now.
    cand_s     = req & ~grant;
    idle_sel_d = pick(req, idle_start_s);
    hold_sel_d = pick(cand_s, hold_start_s);
  end

  // Transfer FSM with registered valid and regId.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_regid_q <= {IDW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            out_regid_q <= idle_sel_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (accept_s && (|cand_s)) begin
            out_regid_q <= hold_sel_d;
          end else if (accept_s) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_regid = out_regid_q;

endmodule
